if_id_buffer: RTL and testbench

- Pipeline register between the fetch stage and the decode stage.
- Each cycle it captures the fetched 16-bit instruction word and pc_plus_one.
- Two-word instructions (opcode word followed by a 16-bit immediate word) are assembled into a single decode bundle.
- Stall holds the register contents; flush replaces the held or pending contents with a NOP bubble.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/if_id_buffer.sv | 102 ++++++++++
 tb/tb_if_id_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: instruction-class constants, the IF/ID
// assembly state type and the decode bundle reused by later pipeline registers.
package cpu_pkg;

  localparam logic [15:0] NOP_CODE     = 16'h4000;
  localparam logic [1:0]  IMM_CLASS    = 2'b11;
  localparam int unsigned BUNDLE_PC_W  = 32;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_IMM = 1'b1
  } if_id_state_t;

  typedef struct packed {
    logic [15:0]            instruction;
    logic [15:0]            immediate;
    logic [BUNDLE_PC_W-1:0] pc_plus_one;
    logic                   valid;
  } if_id_bundle_t;

  // True when the word is the opcode half of a two-word instruction.
  function automatic logic is_two_word(input logic [15:0] word);
    return word[15:14] == IMM_CLASS;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// Fetch/decode pipeline register. Assembles two-word instructions (opcode plus
// immediate) into one decode bundle; stall freezes everything, flush bubbles.
module if_id_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [15:0]     in_instruction,
  input  logic [PC_W-1:0] in_pc_plus_one,
  input  logic            stall,
  input  logic            flush,
  output logic [15:0]     out_instruction,
  output logic [15:0]     out_immediate,
  output logic [PC_W-1:0] out_pc_plus_one,
  output logic            out_valid,
  output logic            imm_pending
);

  if_id_state_t    state_q, state_d;
  logic [15:0]     hold_instr_q, hold_instr_d;
  logic [15:0]     instr_d, imm_d;
  logic [PC_W-1:0] pc_d;
  logic            valid_d, pending_d;

  // NOTE: every variable gets its hold value first so no path through the
  // case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    hold_instr_d = hold_instr_q;
    instr_d      = out_instruction;
    imm_d        = out_immediate;
    pc_d         = out_pc_plus_one;
    valid_d      = out_valid;
    pending_d    = imm_pending;

    if (flush) begin
      // Bubble keeps the last pc so downstream redirect logic still sees it.
      state_d   = S_IDLE;
      pending_d = 1'b0;
      instr_d   = NOP_CODE;
      imm_d     = 16'h0000;
      valid_d   = 1'b0;
    end else if (!stall) begin
      instr_d = NOP_CODE;
      imm_d   = 16'h0000;
      valid_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_two_word(in_instruction)) begin
              hold_instr_d = in_instruction;
              pending_d    = 1'b1;
              state_d      = S_WAIT_IMM;
            end else begin
              instr_d = in_instruction;
              pc_d    = in_pc_plus_one;
              valid_d = 1'b1;
            end
          end
        end
        S_WAIT_IMM: begin
          // The second word is raw immediate data; its top bits mean nothing.
          if (in_valid) begin
            instr_d   = hold_instr_q;
            imm_d     = in_instruction;
            pc_d      = in_pc_plus_one;
            valid_d   = 1'b1;
            pending_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      hold_instr_q    <= NOP_CODE;
      out_instruction <= NOP_CODE;
      out_immediate   <= 16'h0000;
      out_pc_plus_one <= '0;
      out_valid       <= 1'b0;
      imm_pending     <= 1'b0;
    end else begin
      state_q         <= state_d;
      hold_instr_q    <= hold_instr_d;
      out_instruction <= instr_d;
      out_immediate   <= imm_d;
      out_pc_plus_one <= pc_d;
      out_valid       <= valid_d;
      imm_pending     <= pending_d;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed-vector bench for if_id_buffer: the driver queues the expected
// post-edge outputs, an independent monitor pops and compares each cycle.
module tb_if_id_buffer;
  import cpu_pkg::*;

  localparam int unsigned PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [15:0]     in_instruction;
  logic [PC_W-1:0] in_pc_plus_one;
  logic            stall;
  logic            flush;
  logic [15:0]     out_instruction;
  logic [15:0]     out_immediate;
  logic [PC_W-1:0] out_pc_plus_one;
  logic            out_valid;
  logic            imm_pending;

  typedef struct {
    if_id_bundle_t b;
    logic          pending;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  if_id_buffer #(.PC_W(PC_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_instruction (in_instruction),
    .in_pc_plus_one (in_pc_plus_one),
    .stall          (stall),
    .flush          (flush),
    .out_instruction(out_instruction),
    .out_immediate  (out_immediate),
    .out_pc_plus_one(out_pc_plus_one),
    .out_valid      (out_valid),
    .imm_pending    (imm_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string name, input logic rst, input logic v,
                      input logic [15:0] instr, input logic [31:0] pc,
                      input logic stl, input logic fl,
                      input logic [15:0] e_instr, input logic [15:0] e_imm,
                      input logic [31:0] e_pc, input logic e_valid, input logic e_pend);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    in_valid       = v;
    in_instruction = v ? instr : 16'hzzzz;
    in_pc_plus_one = v ? pc : 32'hzzzz_zzzz;
    stall          = stl;
    flush          = fl;
    e.b.instruction = e_instr;
    e.b.immediate   = e_imm;
    e.b.pc_plus_one = e_pc;
    e.b.valid       = e_valid;
    e.pending       = e_pend;
    e.name          = name;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".instr"},   32'(out_instruction), 32'(e.b.instruction));
        check({e.name, ".imm"},     32'(out_immediate),   32'(e.b.immediate));
        check({e.name, ".pc"},      32'(out_pc_plus_one), e.b.pc_plus_one);
        check({e.name, ".valid"},   32'(out_valid),       32'(e.b.valid));
        check({e.name, ".pending"}, 32'(imm_pending),     32'(e.pending));
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pc_plus_one = '0;
    stall = 1'b0; flush = 1'b0;

    //    name        rst v  instr     pc  stl fl   e_instr   e_imm     e_pc v  pend
    step("reset0",    1, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000,  0, 0, 0);
    step("reset1",    1, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000,  0, 0, 0);
    step("idle",      0, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000,  0, 0, 0);
    step("one_word",  0, 1, 16'h1234, 33, 0, 0,  16'h1234, 16'h0000, 33, 1, 0);
    step("two_w_op",  0, 1, 16'hC105, 34, 0, 0,  16'h4000, 16'h0000, 33, 0, 1);
    step("two_w_imm", 0, 1, 16'h00FF, 35, 0, 0,  16'hC105, 16'h00FF, 35, 1, 0);
    step("pre_stall", 0, 1, 16'h1234, 36, 0, 0,  16'h1234, 16'h0000, 36, 1, 0);
    step("stall0",    0, 1, 16'h5555, 40, 1, 0,  16'h1234, 16'h0000, 36, 1, 0);
    step("stall1",    0, 1, 16'hC0DE, 41, 1, 0,  16'h1234, 16'h0000, 36, 1, 0);
    step("stall2",    0, 0, 16'h0000,  0, 1, 0,  16'h1234, 16'h0000, 36, 1, 0);
    step("unstall",   0, 1, 16'h2222, 43, 0, 0,  16'h2222, 16'h0000, 43, 1, 0);
    step("fl_op",     0, 1, 16'hC105, 44, 0, 0,  16'h4000, 16'h0000, 43, 0, 1);
    step("flush_imm", 0, 1, 16'h00FF, 45, 0, 1,  16'h4000, 16'h0000, 43, 0, 0);
    step("post_fl",   0, 1, 16'h2000, 46, 0, 0,  16'h2000, 16'h0000, 46, 1, 0);
    step("fl_stall",  0, 1, 16'h3333, 47, 1, 1,  16'h4000, 16'h0000, 46, 0, 0);
    step("idle_z",    0, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000, 46, 0, 0);
    step("w_op",      0, 1, 16'hC105, 48, 0, 0,  16'h4000, 16'h0000, 46, 0, 1);
    step("w_stall",   0, 1, 16'hFFFF, 49, 1, 0,  16'h4000, 16'h0000, 46, 0, 1);
    step("w_gap",     0, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000, 46, 0, 1);
    step("w_imm_cls", 0, 1, 16'hFFFF, 50, 0, 0,  16'hC105, 16'hFFFF, 50, 1, 0);
    step("r_op",      0, 1, 16'hC105, 51, 0, 0,  16'h4000, 16'h0000, 50, 0, 1);
    step("r_mid",     1, 1, 16'h0001, 52, 0, 0,  16'h4000, 16'h0000,  0, 0, 0);
    step("r_after",   0, 1, 16'h0001, 53, 0, 0,  16'h0001, 16'h0000, 53, 1, 0);
    step("tail",      0, 0, 16'h0000,  0, 0, 0,  16'h4000, 16'h0000, 53, 0, 0);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
